alu_reservation_station: RTL
============================

# alu_reservation_station

Out-of-order issue buffer and scheduler for the single shared arithmetic_logic_unit. It holds up to RS_SIZE decoded ALU/branch instructions, captures operand values from the ALU and load-store result broadcasts (wake-up), and each cycle dispatches the lowest-index ready entry by registering its fields onto the ALU input bus. It sits between the issue stage (decoder/ROB allocation) and the ALU.

## Interface
- RS_SIZE, 16, entry count (power of two, ≥ 2).
- RS_IDX_W, 4, log2(RS_SIZE).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low all state and outputs hold.
- clear  in  1  misprediction flush from ROB.
- issue_valid  in  1  new instruction this cycle.
- issue_opcode  in  6  internal opcode (non-zero).
- issue_val1 / issue_val2  in  32  operand values, meaningful when the matching tag flag is 0.
- issue_q1_valid / issue_q2_valid  in  1  operand still pending.
- issue_q1 / issue_q2  in  6  ROB index producing the pending operand.
- issue_imm, issue_pc  in  32  passed through.
- issue_rob_index  in  6  destination ROB entry.
- alu_valid, alu_res[31:0], alu_rob_index[5:0]  in  ALU result broadcast.
- lsb_valid, lsb_res[31:0], lsb_rob_index[5:0]  in  load-store result broadcast.
- full  out  1  all entries busy.
- exe_opcode  out  6  to ALU; 0 = no operation.
- exe_val1, exe_val2, exe_imm, exe_pc  out  32  to ALU.
- exe_rob_index  out  6  to ALU.

## Operation
- Entry state: busy, opcode, val1, val2, q1_valid, q1, q2_valid, q2, imm, pc, rob_index.
- Ready: busy && !q1_valid && !q2_valid.
- Free slot: lowest-index non-busy entry. Issue with full=1 is a protocol violation; the request is dropped.
- Issue: on issue_valid, write to free slot, busy=1. Issue-time bypass: if a pending issue tag equals a same-cycle valid broadcast tag, store the broadcast value and clear that q flag.
- Wake-up: for every busy entry, pending operand whose tag matches alu_rob_index (alu_valid) or lsb_rob_index (lsb_valid) captures the result and clears its q flag. If both buses carry the same tag, ALU wins.
- Dispatch: select lowest-index ready entry among entries as of the start of the cycle (entries issued or woken this cycle are not eligible). Register its fields to exe_*, clear busy. If no entry is ready, exe_opcode=0 and other exe_* hold.
- clear: all busy=0, exe_opcode=0; overrides issue, wake-up and dispatch in the same cycle.
- rst: as clear, plus every exe_* output = 0 and full=0. rst has priority over rdy.
- rdy=0: no issue, wake-up or dispatch; broadcasts during that cycle are ignored.

## Timing
- full combinational from busy vector (registered state only).
- Issue at edge N → earliest dispatch at edge N+1 → ALU result combinational in cycle N+1 → dependent entry woken at edge N+2 → dispatched at edge N+3.
- exe_opcode high for exactly one cycle per dispatched instruction.
- Slot freed by dispatch at edge N is reusable by an issue at edge N+1 (full drops after edge N).
- Reset: one cycle of rst clears everything; first issue accepted on the edge after rst falls.

## Structure
- Shared config.v: opcode defines (existing), RS_SIZE, RS_IDX_W, ROB_IDX_W=6.
- Sub-module rs_priority_encoder (RS_SIZE-bit request vector → found flag + lowest index); instantiated twice, free-slot and ready-select.
- Remaining logic: entry array, wake-up compare per entry, output registers.

## Test plan
- Reset then issue ADD (val1=3, val2=4, no deps, rob 5) → next cycle exe_opcode=ADD, exe_val1=3, exe_val2=4, exe_rob_index=5; entry freed.
- Issue SUB dep q1=7 into slot 0, ADDI ready into slot 1 → ADDI dispatches first; drive lsb_valid, lsb_rob_index=7, lsb_res=100 → SUB dispatches next cycle with exe_val1=100.
- Issue with issue_q2=9 while alu_valid, alu_rob_index=9, alu_res=0xDEAD in same cycle → entry dispatches next cycle with exe_val2=0xDEAD.
- Fill 16 entries all pending tag 3 → full=1, extra issue dropped; broadcast tag 3 → entries dispatch one per cycle in index order 0..15, full falls after first dispatch.
- With 4 busy entries assert clear together with issue_valid → full=0, no dispatch ever follows, exe_opcode=0.
- Hold rdy=0 for 3 cycles with ready entries and broadcasts → no dispatch, no wake-up, outputs unchanged; resume on rdy=1.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared configuration for the ALU reservation station: widths, opcodes,
// the entry record and the operand wake-up helper.
package alu_reservation_station_pkg;

    localparam int RS_SIZE_DFLT = 16;
    localparam int ROB_IDX_W    = 6;
    localparam int DATA_W       = 32;
    localparam int OPC_W        = 6;

    // Internal opcodes; zero is reserved as "no operation" on the ALU bus.
    localparam logic [OPC_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'd3;
    localparam logic [OPC_W-1:0] OP_AND  = 6'd4;
    localparam logic [OPC_W-1:0] OP_OR   = 6'd5;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'd6;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'd7;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'd8;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [DATA_W-1:0]    val1;
        logic [DATA_W-1:0]    val2;
        logic                 q1_valid;
        logic [ROB_IDX_W-1:0] q1;
        logic                 q2_valid;
        logic [ROB_IDX_W-1:0] q2;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_IDX_W-1:0] rob_index;
    } rs_entry_t;

    typedef struct packed {
        logic              pend;
        logic [DATA_W-1:0] val;
    } operand_t;

    // Resolve one operand against both result buses; the ALU bus wins when
    // both carry the same tag.
    function automatic operand_t wake_operand(
        input logic                 pend,
        input logic [ROB_IDX_W-1:0] tag,
        input logic [DATA_W-1:0]    val,
        input logic                 alu_v,
        input logic [ROB_IDX_W-1:0] alu_tag,
        input logic [DATA_W-1:0]    alu_val,
        input logic                 lsb_v,
        input logic [ROB_IDX_W-1:0] lsb_tag,
        input logic [DATA_W-1:0]    lsb_val
    );
        operand_t r;
        r.pend = pend;
        r.val  = val;
        if (pend && alu_v && (alu_tag == tag)) begin
            r.pend = 1'b0;
            r.val  = alu_val;
        end else if (pend && lsb_v && (lsb_tag == tag)) begin
            r.pend = 1'b0;
            r.val  = lsb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// Lowest-index-first priority encoder used for free-slot and ready selection.
module rs_priority_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set request is the last one kept.
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Issue buffer and scheduler for the shared ALU: holds decoded instructions,
// captures operands from the result buses and dispatches the lowest-index
// ready entry onto a registered ALU input bus each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DFLT,
    parameter int RS_IDX_W = $clog2(RS_SIZE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        issue_valid,
    input  logic [5:0]  issue_opcode,
    input  logic [31:0] issue_val1,
    input  logic [31:0] issue_val2,
    input  logic        issue_q1_valid,
    input  logic        issue_q2_valid,
    input  logic [5:0]  issue_q1,
    input  logic [5:0]  issue_q2,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,
    input  logic [5:0]  issue_rob_index,
    input  logic        alu_valid,
    input  logic [31:0] alu_res,
    input  logic [5:0]  alu_rob_index,
    input  logic        lsb_valid,
    input  logic [31:0] lsb_res,
    input  logic [5:0]  lsb_rob_index,
    output logic        full,
    output logic [5:0]  exe_opcode,
    output logic [31:0] exe_val1,
    output logic [31:0] exe_val2,
    output logic [31:0] exe_imm,
    output logic [31:0] exe_pc,
    output logic [5:0]  exe_rob_index
);

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    rs_entry_t            ent_q [RS_SIZE];
    rs_entry_t            ent_d [RS_SIZE];

    logic [OPC_W-1:0]     exe_opcode_q, exe_opcode_d;
    logic [DATA_W-1:0]    exe_val1_q, exe_val1_d;
    logic [DATA_W-1:0]    exe_val2_q, exe_val2_d;
    logic [DATA_W-1:0]    exe_imm_q, exe_imm_d;
    logic [DATA_W-1:0]    exe_pc_q, exe_pc_d;
    logic [ROB_IDX_W-1:0] exe_rob_q, exe_rob_d;

    logic [RS_SIZE-1:0]   ready_vec;
    logic                 free_found, rdy_found;
    logic [RS_IDX_W-1:0]  free_idx, rdy_idx;

    // Readiness is taken from registered state only, so entries written or
    // woken this cycle cannot be dispatched until the following edge.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] && !ent_q[i].q1_valid && !ent_q[i].q2_valid;
        end
    end

    rs_priority_encoder #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_priority_encoder #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_enc (
        .req_i   (ready_vec),
        .found_o (rdy_found),
        .idx_o   (rdy_idx)
    );

    assign full = &busy_q;

    // Next state: flush, then wake-up, dispatch and issue; all held when rdy is low.
    always_comb begin
        busy_d       = busy_q;
        ent_d        = ent_q;
        exe_opcode_d = exe_opcode_q;
        exe_val1_d   = exe_val1_q;
        exe_val2_d   = exe_val2_q;
        exe_imm_d    = exe_imm_q;
        exe_pc_d     = exe_pc_q;
        exe_rob_d    = exe_rob_q;

        if (rdy) begin
            if (clear) begin
                busy_d       = '0;
                exe_opcode_d = OP_NOP;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        {ent_d[i].q1_valid, ent_d[i].val1} = wake_operand(
                            ent_q[i].q1_valid, ent_q[i].q1, ent_q[i].val1,
                            alu_valid, alu_rob_index, alu_res,
                            lsb_valid, lsb_rob_index, lsb_res);
                        {ent_d[i].q2_valid, ent_d[i].val2} = wake_operand(
                            ent_q[i].q2_valid, ent_q[i].q2, ent_q[i].val2,
                            alu_valid, alu_rob_index, alu_res,
                            lsb_valid, lsb_rob_index, lsb_res);
                    end
                end

                if (rdy_found) begin
                    busy_d[rdy_idx] = 1'b0;
                    exe_opcode_d    = ent_q[rdy_idx].opcode;
                    exe_val1_d      = ent_q[rdy_idx].val1;
                    exe_val2_d      = ent_q[rdy_idx].val2;
                    exe_imm_d       = ent_q[rdy_idx].imm;
                    exe_pc_d        = ent_q[rdy_idx].pc;
                    exe_rob_d       = ent_q[rdy_idx].rob_index;
                end else begin
                    exe_opcode_d = OP_NOP;
                end

                // The free slot is never the dispatched one (it is not busy),
                // so issue and dispatch cannot collide. A full station drops it.
                if (issue_valid && free_found) begin
                    busy_d[free_idx]           = 1'b1;
                    ent_d[free_idx].opcode     = issue_opcode;
                    ent_d[free_idx].q1         = issue_q1;
                    ent_d[free_idx].q2         = issue_q2;
                    ent_d[free_idx].imm        = issue_imm;
                    ent_d[free_idx].pc         = issue_pc;
                    ent_d[free_idx].rob_index  = issue_rob_index;
                    {ent_d[free_idx].q1_valid, ent_d[free_idx].val1} = wake_operand(
                        issue_q1_valid, issue_q1, issue_val1,
                        alu_valid, alu_rob_index, alu_res,
                        lsb_valid, lsb_rob_index, lsb_res);
                    {ent_d[free_idx].q2_valid, ent_d[free_idx].val2} = wake_operand(
                        issue_q2_valid, issue_q2, issue_val2,
                        alu_valid, alu_rob_index, alu_res,
                        lsb_valid, lsb_rob_index, lsb_res);
                end
            end
        end
    end

    // Control state and the ALU output bus; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            exe_opcode_q <= OP_NOP;
            exe_val1_q   <= '0;
            exe_val2_q   <= '0;
            exe_imm_q    <= '0;
            exe_pc_q     <= '0;
            exe_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            exe_opcode_q <= exe_opcode_d;
            exe_val1_q   <= exe_val1_d;
            exe_val2_q   <= exe_val2_d;
            exe_imm_q    <= exe_imm_d;
            exe_pc_q     <= exe_pc_d;
            exe_rob_q    <= exe_rob_d;
        end
    end

    // Entry payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign exe_opcode    = exe_opcode_q;
    assign exe_val1      = exe_val1_q;
    assign exe_val2      = exe_val2_q;
    assign exe_imm       = exe_imm_q;
    assign exe_pc        = exe_pc_q;
    assign exe_rob_index = exe_rob_q;

endmodule
